riscv_nn_wb_arbiter: RTL and testbench

- Write-back merge stage directly upstream of the latch-based integer/FP register file.
- Drives the register file's two write ports (A and B) from three producers:
  - EX result: fixed 1-cycle, no backpressure.
  - LSU load result: no backpressure.
  - NN/TNN unit: multi-cycle, bursty, valid/ready.
- NN results are buffered in a small FIFO and drained into idle write-port slots, up to two per cycle.
- Per-register busy bitmap drives decode-stage RAW/WAW stalls.

---
 rtl/riscv_nn_wb_pkg.sv | 25 ++
 rtl/riscv_nn_wb_arbiter_if.sv | 52 +++++
 rtl/riscv_nn_wb_fifo.sv | 84 ++++++++
 rtl/riscv_nn_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_riscv_nn_wb_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_nn_wb_pkg.sv
// riscv_nn_wb_pkg: shared types, defaults and helpers for the NN write-back merge stage.
// Revision 1.0 - initial release.
`default_nettype none

package riscv_nn_wb_pkg;

  localparam int NN_WB_DEPTH_DEF = 4;
  localparam int NN_WB_ADDR_DEF  = 5;
  localparam int NN_WB_DATA_DEF  = 32;
  // Widest register index supported (integer + FP register files merged).
  localparam int NN_WB_ADDR_MAX  = 6;
  localparam int NN_WB_REGS_MAX  = 2 ** NN_WB_ADDR_MAX;

  typedef struct packed {
    logic [NN_WB_ADDR_DEF-1:0] addr;
    logic [NN_WB_DATA_DEF-1:0] data;
  } wb_req_t;

  function automatic logic [NN_WB_REGS_MAX-1:0] onehot_addr(input logic [NN_WB_ADDR_MAX-1:0] addr);
    return NN_WB_REGS_MAX'(1) << addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_nn_wb_arbiter_if.sv
// riscv_nn_wb_arbiter_if: producer and register-file write-port bundle of the write-back stage.
// Revision 1.0 - initial release.
`default_nettype none

interface riscv_nn_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
);

  logic                  ex_we_i;
  logic [ADDR_WIDTH-1:0] ex_waddr_i;
  logic [DATA_WIDTH-1:0] ex_wdata_i;
  logic                  lsu_we_i;
  logic [ADDR_WIDTH-1:0] lsu_waddr_i;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;
  logic                  nn_valid_i;
  logic                  nn_ready_o;
  logic [ADDR_WIDTH-1:0] nn_waddr_i;
  logic [DATA_WIDTH-1:0] nn_wdata_i;
  logic                  we_a_o;
  logic [ADDR_WIDTH-1:0] waddr_a_o;
  logic [DATA_WIDTH-1:0] wdata_a_o;
  logic                  we_b_o;
  logic [ADDR_WIDTH-1:0] waddr_b_o;
  logic [DATA_WIDTH-1:0] wdata_b_o;
  logic [NUM_REGS-1:0]   busy_o;
  logic                  nn_empty_o;

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    input  nn_valid_i, nn_waddr_i, nn_wdata_i,
    output nn_ready_o,
    output we_a_o, waddr_a_o, wdata_a_o,
    output we_b_o, waddr_b_o, wdata_b_o,
    output busy_o, nn_empty_o
  );

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    output nn_valid_i, nn_waddr_i, nn_wdata_i,
    input  nn_ready_o,
    input  we_a_o, waddr_a_o, wdata_a_o,
    input  we_b_o, waddr_b_o, wdata_b_o,
    input  busy_o, nn_empty_o
  );

endinterface

`default_nettype wire

// File: rtl/riscv_nn_wb_fifo.sv
// riscv_nn_wb_fifo: in-order NN result buffer, one push and up to two pops per cycle.
// Revision 1.0 - initial release.
`default_nettype none

module riscv_nn_wb_fifo
  import riscv_nn_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = NN_WB_DEPTH_DEF,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  wire logic                            clk,
  input  wire logic                            rst_n,
  input  wire logic                            push,
  input  wire logic [ADDR_WIDTH-1:0]           push_addr,
  input  wire logic [DATA_WIDTH-1:0]           push_data,
  input  wire logic [1:0]                      pop_cnt,
  output logic      [ADDR_WIDTH-1:0]           head_addr,
  output logic      [DATA_WIDTH-1:0]           head_data,
  output logic      [ADDR_WIDTH-1:0]           next_addr,
  output logic      [DATA_WIDTH-1:0]           next_data,
  output logic      [PTR_W:0]                  count,
  output logic      [DEPTH-1:0]                entry_valid,
  output logic      [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr
);

  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [PTR_W:0]        count_q;
  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // A pushed slot is always free, so it never collides with a popped one.
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop_cnt != 2'd0) valid_q[rd_ptr]     <= 1'b0;
      if (pop_cnt == 2'd2) valid_q[rd_ptr_nxt] <= 1'b0;
      rd_ptr  <= rd_ptr + PTR_W'(pop_cnt);
      count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr   = addr_mem[rd_ptr];
  assign head_data   = data_mem[rd_ptr];
  assign next_addr   = addr_mem[rd_ptr_nxt];
  assign next_data   = data_mem[rd_ptr_nxt];
  assign count       = count_q;
  assign entry_valid = valid_q;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign entry_addr[i] = addr_mem[i];
    end
  endgenerate

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count_q < (PTR_W+1)'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (PTR_W+1)'(pop_cnt) <= count_q);

endmodule

`default_nettype wire

// File: rtl/riscv_nn_wb_arbiter.sv
// riscv_nn_wb_arbiter: merges EX, LSU and buffered NN results onto the two register-file write ports.
// Revision 1.0 - initial release.
`default_nettype none

module riscv_nn_wb_arbiter
  import riscv_nn_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NN_DEPTH   = NN_WB_DEPTH_DEF,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  riscv_nn_wb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NN_DEPTH);

  logic                             push;
  logic [1:0]                       pop_cnt;
  logic                             fifo_empty;
  logic                             a_from_fifo;
  logic                             b_from_fifo;
  logic [ADDR_WIDTH-1:0]            head_addr;
  logic [DATA_WIDTH-1:0]            head_data;
  logic [ADDR_WIDTH-1:0]            next_addr;
  logic [DATA_WIDTH-1:0]            next_data;
  logic [PTR_W:0]                   count;
  logic [NN_DEPTH-1:0]              entry_valid;
  logic [NN_DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr;
  logic [NN_WB_REGS_MAX-1:0]        busy_full;

  riscv_nn_wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NN_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_addr   (bus.nn_waddr_i),
    .push_data   (bus.nn_wdata_i),
    .pop_cnt     (pop_cnt),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .next_addr   (next_addr),
    .next_data   (next_data),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Ready looks only at the registered count, never at this cycle's pops.
  assign bus.nn_ready_o = (count < (PTR_W+1)'(NN_DEPTH));
  assign fifo_empty     = (count == '0);
  assign bus.nn_empty_o = fifo_empty;
  // r0 writes are architecturally discarded, so they never occupy a slot.
  assign push           = bus.nn_valid_i && bus.nn_ready_o && (bus.nn_waddr_i != '0);

  always_comb begin
    bus.we_a_o    = 1'b0;
    bus.waddr_a_o = '0;
    bus.wdata_a_o = '0;
    a_from_fifo   = 1'b0;
    if (bus.ex_we_i) begin
      bus.we_a_o    = 1'b1;
      bus.waddr_a_o = bus.ex_waddr_i;
      bus.wdata_a_o = bus.ex_wdata_i;
    end else if (!fifo_empty) begin
      bus.we_a_o    = 1'b1;
      bus.waddr_a_o = head_addr;
      bus.wdata_a_o = head_data;
      a_from_fifo   = 1'b1;
    end

    bus.we_b_o    = 1'b0;
    bus.waddr_b_o = '0;
    bus.wdata_b_o = '0;
    b_from_fifo   = 1'b0;
    if (bus.lsu_we_i) begin
      bus.we_b_o    = 1'b1;
      bus.waddr_b_o = bus.lsu_waddr_i;
      bus.wdata_b_o = bus.lsu_wdata_i;
    end else if (bus.ex_we_i && !fifo_empty) begin
      bus.we_b_o    = 1'b1;
      bus.waddr_b_o = head_addr;
      bus.wdata_b_o = head_data;
      b_from_fifo   = 1'b1;
    end else if (a_from_fifo && (count >= (PTR_W+1)'(2))) begin
      // Younger entry on B: the register file lets B win a same-address clash.
      bus.we_b_o    = 1'b1;
      bus.waddr_b_o = next_addr;
      bus.wdata_b_o = next_data;
      b_from_fifo   = 1'b1;
    end
  end

  assign pop_cnt = {1'b0, a_from_fifo} + {1'b0, b_from_fifo};

  always_comb begin
    busy_full = '0;
    for (int i = 0; i < NN_DEPTH; i++) begin
      if (entry_valid[i]) busy_full |= onehot_addr(NN_WB_ADDR_MAX'(entry_addr[i]));
    end
  end

  assign bus.busy_o = busy_full[NUM_REGS-1:0];

  generate
    if (NUM_REGS < NN_WB_REGS_MAX) begin : g_busy_hi
      logic unused_busy_hi;
      assign unused_busy_hi = ^busy_full[NN_WB_REGS_MAX-1:NUM_REGS];
    end
  endgenerate

  a_ex_hazard: assert property (@(posedge clk) disable iff (!rst_n)
    bus.ex_we_i |-> !bus.busy_o[bus.ex_waddr_i]);
  a_lsu_hazard: assert property (@(posedge clk) disable iff (!rst_n)
    bus.lsu_we_i |-> !bus.busy_o[bus.lsu_waddr_i]);

endmodule

`default_nettype wire

// File: tb/tb_riscv_nn_wb_arbiter.sv
// tb_riscv_nn_wb_arbiter: directed and random stimulus against a queue-based write-back model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_riscv_nn_wb_arbiter;
  import riscv_nn_wb_pkg::*;

  localparam int AW    = NN_WB_ADDR_DEF;
  localparam int DW    = NN_WB_DATA_DEF;
  localparam int DEPTH = 4;
  localparam int NR    = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_nn_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  riscv_nn_wb_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NN_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  wb_req_t         q[$];
  logic [DW-1:0]   rf [NR];
  logic            cur_ex_we, cur_lsu_we, cur_nv;
  logic [AW-1:0]   cur_na;
  logic [DW-1:0]   cur_nd;
  logic            exp_ready;
  logic            s_we_a, s_we_b;
  logic [AW-1:0]   s_a_a, s_a_b;
  logic [DW-1:0]   s_d_a, s_d_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] model_busy();
    logic [NR-1:0] b = '0;
    foreach (q[i]) b[q[i].addr] = 1'b1;
    return b;
  endfunction

  task automatic check_outputs();
    int            sz = q.size();
    int            idx_b;
    logic          ea, eb;
    logic [AW-1:0] aa, ab;
    logic [DW-1:0] da, db;
    ea = 1'b0; aa = '0; da = '0;
    eb = 1'b0; ab = '0; db = '0;
    if (cur_ex_we) begin
      ea = 1'b1; aa = bus.ex_waddr_i; da = bus.ex_wdata_i;
    end else if (sz > 0) begin
      ea = 1'b1; aa = q[0].addr; da = q[0].data;
    end
    // B takes the oldest queued entry that A did not consume.
    idx_b = cur_ex_we ? 0 : 1;
    if (cur_lsu_we) begin
      eb = 1'b1; ab = bus.lsu_waddr_i; db = bus.lsu_wdata_i;
    end else if (sz > idx_b) begin
      eb = 1'b1; ab = q[idx_b].addr; db = q[idx_b].data;
    end
    exp_ready = (sz < DEPTH);
    check("we_a", bus.we_a_o, ea);
    check("waddr_a", bus.waddr_a_o, aa);
    check("wdata_a", bus.wdata_a_o, da);
    check("we_b", bus.we_b_o, eb);
    check("waddr_b", bus.waddr_b_o, ab);
    check("wdata_b", bus.wdata_b_o, db);
    check("nn_ready", bus.nn_ready_o, exp_ready);
    check("nn_empty", bus.nn_empty_o, sz == 0);
    check("busy", bus.busy_o, model_busy());
    s_we_a = bus.we_a_o; s_a_a = bus.waddr_a_o; s_d_a = bus.wdata_a_o;
    s_we_b = bus.we_b_o; s_a_b = bus.waddr_b_o; s_d_b = bus.wdata_b_o;
  endtask

  task automatic update_model();
    int sz = q.size();
    int slots = (cur_ex_we ? 0 : 1) + (cur_lsu_we ? 0 : 1);
    int pops = (slots < sz) ? slots : sz;
    repeat (pops) void'(q.pop_front());
    if (cur_nv && exp_ready && cur_na != '0) q.push_back('{addr: cur_na, data: cur_nd});
    if (s_we_a) rf[s_a_a] = s_d_a;
    if (s_we_b) rf[s_a_b] = s_d_b;
  endtask

  task automatic step(input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input logic lw, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input logic nv, input logic [AW-1:0] na, input logic [DW-1:0] nd);
    @(negedge clk);
    bus.ex_we_i  = ew; bus.ex_waddr_i  = ea; bus.ex_wdata_i  = ed;
    bus.lsu_we_i = lw; bus.lsu_waddr_i = la; bus.lsu_wdata_i = ld;
    bus.nn_valid_i = nv; bus.nn_waddr_i = na; bus.nn_wdata_i = nd;
    cur_ex_we = ew; cur_lsu_we = lw; cur_nv = nv; cur_na = na; cur_nd = nd;
    #1;
    check_outputs();
    @(posedge clk);
    update_model();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // EX to x10, LSU to x11 keeps both ports busy while the FIFO fills.
  task automatic push_blocked(input logic [AW-1:0] na, input logic [DW-1:0] nd);
    step(1'b1, 5'd10, $urandom(), 1'b1, 5'd11, $urandom(), 1'b1, na, nd);
  endtask

  initial begin
    logic [NR-1:0] b;
    logic          ew, lw, nv;
    logic [AW-1:0] ea, la;
    bus.ex_we_i = 1'b0; bus.ex_waddr_i = '0; bus.ex_wdata_i = '0;
    bus.lsu_we_i = 1'b0; bus.lsu_waddr_i = '0; bus.lsu_wdata_i = '0;
    bus.nn_valid_i = 1'b0; bus.nn_waddr_i = '0; bus.nn_wdata_i = '0;
    for (int i = 0; i < NR; i++) rf[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5, 32'hA5A5A5A5);
    idle();
    idle();

    for (int i = 1; i <= 4; i++) push_blocked(AW'(i), DW'(32'h100 + i));
    push_blocked(5'd6, 32'hDEAD);
    #2;
    check("busy_full", bus.busy_o, 32'h0000001E);
    check("ready_full", bus.nn_ready_o, 1'b0);
    idle();
    idle();
    #2;
    check("drained_empty", bus.nn_empty_o, 1'b1);
    check("drained_busy", bus.busy_o, 32'h0);

    push_blocked(5'd7, 32'h7777);
    push_blocked(5'd8, 32'h8888);
    step(1'b1, 5'd3, 32'h3333, 1'b0, '0, '0, 1'b0, '0, '0);
    idle();

    for (int i = 12; i <= 15; i++) push_blocked(AW'(i), DW'(i));
    step(1'b1, 5'd20, 32'h2020, 1'b0, '0, '0, 1'b1, 5'd16, 32'h1616);
    step(1'b1, 5'd20, 32'h2121, 1'b1, 5'd21, 32'h2222, 1'b1, 5'd16, 32'h1616);
    repeat (3) idle();

    push_blocked(5'd9, 32'd1);
    push_blocked(5'd9, 32'd2);
    idle();
    #2;
    check("rf_x9", rf[9], 32'd2);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
    idle();

    for (int i = 1; i <= 3; i++) push_blocked(AW'(20 + i), DW'(i));
    @(negedge clk);
    bus.ex_we_i = 1'b0; bus.lsu_we_i = 1'b0; bus.nn_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_empty", bus.nn_empty_o, 1'b1);
    check("rst_busy", bus.busy_o, 32'h0);
    check("rst_ready", bus.nn_ready_o, 1'b1);
    check("rst_we_a", bus.we_a_o, 1'b0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();

    for (int n = 0; n < 400; n++) begin
      b  = model_busy();
      ew = ($urandom_range(0, 1) == 1);
      lw = ($urandom_range(0, 2) == 0);
      nv = ($urandom_range(0, 9) < 7);
      do ea = AW'($urandom_range(0, NR - 1)); while (b[ea]);
      do la = AW'($urandom_range(0, NR - 1)); while (b[la]);
      step(ew, ea, $urandom(), lw, la, $urandom(), nv, AW'($urandom_range(0, NR - 1)), $urandom());
    end
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
